// File: rtl/main_memory_responder.sv
// Word-addressed main-memory slave: single-word writes, pipelined in-order reads with fixed latency.
// Optional pseudo-random read throttling when MEM_RANDOM_STALL_EN is defined.
module main_memory_responder #(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          WORD_WIDTH      = 32,
   parameter int          MEM_DEPTH_LOG2  = 14,
   parameter int          READ_LATENCY    = 4,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] memory_addr,
   input  logic                  memory_write_en,
   input  logic [WORD_WIDTH-1:0] memory_write_data,
   input  logic                  memory_read_addr_valid,
   output logic                  memory_read_ready,
   output logic                  memory_read_valid,
   output logic [WORD_WIDTH-1:0] memory_read_data,
   output logic [4:0]            outstanding_count
);

   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

   logic [WORD_WIDTH-1:0]     mem [DEPTH];
   logic [MEM_DEPTH_LOG2-1:0] idx;

   logic [4:0]              cnt_q, cnt_d;
   logic [READ_LATENCY-1:0] stg_vld_q, stg_vld_d;
   logic [WORD_WIDTH-1:0]   stg_dat_q [READ_LATENCY];
   logic [WORD_WIDTH-1:0]   stg_dat_d [READ_LATENCY];
   logic [READ_LATENCY-1:0] in_vld;
   logic [WORD_WIDTH-1:0]   in_dat [READ_LATENCY];

   logic throttle;
   logic accept;
   logic retire;

   assign idx = memory_addr[MEM_DEPTH_LOG2-1:0];

`ifdef MEM_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign throttle = (lfsr_q[1:0] == 2'b00);
`else
   assign throttle = 1'b0;
`endif

   assign memory_read_ready = (cnt_q < 5'(MAX_OUTSTANDING)) && !throttle;
   // Writes win the shared address bus; a blocked read simply stays pending.
   assign accept            = memory_read_addr_valid && memory_read_ready && !memory_write_en;

   // Array is deliberately unreset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (memory_write_en) begin
         mem[idx] <= memory_write_data;
      end
   end

   // Each stage only loads on valid, so the final stage doubles as the held output data.
   always_comb begin
      in_vld[0] = accept;
      in_dat[0] = mem[idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
         in_vld[i] = stg_vld_q[i-1];
         in_dat[i] = stg_dat_q[i-1];
      end
      for (int i = 0; i < READ_LATENCY; i++) begin
         stg_vld_d[i] = in_vld[i];
         stg_dat_d[i] = in_vld[i] ? in_dat[i] : stg_dat_q[i];
      end
   end

   // A read counts as returned on the edge that raises its valid pulse.
   assign retire = in_vld[READ_LATENCY-1];

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, retire})
         2'b10:   cnt_d = cnt_q + 5'd1;
         2'b01:   cnt_d = cnt_q - 5'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         stg_vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            stg_dat_q[i] <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         stg_vld_q <= stg_vld_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            stg_dat_q[i] <= stg_dat_d[i];
         end
      end
   end

   assign memory_read_valid = stg_vld_q[READ_LATENCY-1];
   assign memory_read_data  = stg_dat_q[READ_LATENCY-1];
   assign outstanding_count = cnt_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: default instance plus a MAX_OUTSTANDING=2 instance.
module tb_main_memory_responder;

   localparam int LAT = 4;
   localparam int MAXO = 8;

   logic        clk;
   logic        rst;
   logic [31:0] addr, wd, rdat;
   logic        we, rd_vld, rdy, vld;
   logic [4:0]  cnt;

   logic [31:0] s_addr, s_wd, s_rdat;
   logic        s_we, s_rd_vld, s_rdy, s_vld;
   logic [4:0]  s_cnt;

   main_memory_responder dut (
      .clk(clk), .rst(rst), .memory_addr(addr), .memory_write_en(we),
      .memory_write_data(wd), .memory_read_addr_valid(rd_vld),
      .memory_read_ready(rdy), .memory_read_valid(vld),
      .memory_read_data(rdat), .outstanding_count(cnt));

   main_memory_responder #(.MAX_OUTSTANDING(2), .READ_LATENCY(4)) dut_small (
      .clk(clk), .rst(rst), .memory_addr(s_addr), .memory_write_en(s_we),
      .memory_write_data(s_wd), .memory_read_addr_valid(s_rd_vld),
      .memory_read_ready(s_rdy), .memory_read_valid(s_vld),
      .memory_read_data(s_rdat), .outstanding_count(s_cnt));

   typedef struct {
      logic [31:0] dat;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mm [int];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        acc_flag = 1'b0;
   logic [31:0] last_dat = '0;
   logic [15:0] mlfsr = 16'hACE1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   function automatic int inflight();
      int n = 0;
      foreach (sb[i]) if (sb[i].due > cyc) n++;
      return n;
   endfunction

   function automatic logic exp_rdy(int n);
`ifdef MEM_RANDOM_STALL_EN
      return (n < MAXO) && (mlfsr[1:0] != 2'b00);
`else
      return (n < MAXO);
`endif
   endfunction

   always @(negedge rst) begin
      sb.delete();
      last_dat = '0;
      mlfsr    = 16'hACE1;
   end

   // Reference model: decides acceptance from the spec rules and queues the expected response.
   always @(posedge clk) begin
      if (!rst) begin
         sb.delete();
         acc_flag = 1'b0;
         mlfsr    = 16'hACE1;
      end else begin
         acc_flag = rd_vld && !we && exp_rdy(inflight());
         if (we) mm[int'(addr[13:0])] = wd;
         if (acc_flag) sb.push_back('{dat: mm[int'(addr[13:0])], due: cyc + LAT});
         cyc++;
         mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      end
   end

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      int   n;
      if (!rst) begin
         check("reset_valid", {31'b0, vld}, 32'd0);
         check("reset_count", {27'b0, cnt}, 32'd0);
         check("reset_data", rdat, 32'd0);
      end else begin
         n = inflight();
         check("count", {27'b0, cnt}, n);
         check("ready", {31'b0, rdy}, {31'b0, exp_rdy(n)});
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("resp_valid", {31'b0, vld}, 32'd1);
            check("resp_data", rdat, e.dat);
            last_dat = e.dat;
         end else begin
            check("idle_valid", {31'b0, vld}, 32'd0);
            check("data_hold", rdat, last_dat);
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wd = d; we = 1'b1; rd_vld = 1'b0;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      bit got = 1'b0;
      addr = a; we = 1'b0; rd_vld = 1'b1;
      for (int t = 0; t < 50 && !got; t++) begin
         @(posedge clk); #1;
         got = acc_flag;
      end
      if (!got) check("read_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      rd_vld = 1'b0; we = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   int   exp_s_cnt [10] = '{1, 2, 2, 1, 1, 2, 2, 1, 1, 2};
   logic exp_s_vld [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

   initial begin
      int j;
      addr = '0; wd = '0; we = 1'b0; rd_vld = 1'b0;
      s_addr = 32'h10; s_wd = '0; s_we = 1'b0; s_rd_vld = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      // Single write then read back.
      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10);
      idle(8);

      // Streaming reads of 16 consecutive words.
      for (int i = 0; i < 16; i++) wr(i, 32'h1000 + i);
      for (int i = 0; i < 16; i++) rd(i);
      idle(8);

      // High address bits alias onto the low index.
      wr(32'h0000_4005, 32'hA5A5_0005);
      rd(32'h5);
      wr(32'h7, 32'h0000_0077);
      rd(32'hFFFF_C007);
      idle(8);

      // Write and read request together: write wins, read goes next cycle.
      addr = 32'h20; wd = 32'h55; we = 1'b1; rd_vld = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
      rd(32'h20);
      idle(8);

      // Reset with reads in flight: all dropped, array contents kept.
      rd(32'h10);
      rd(32'h20);
      rd(32'h5);
      rst = 1'b0; rd_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(8);
      rd(32'h10);
      rd(32'h20);
      idle(8);

`ifndef MEM_RANDOM_STALL_EN
      // MAX_OUTSTANDING=2 instance under continuous requests.
      @(posedge clk); #1;
      s_rd_vld = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("small_count", {27'b0, s_cnt}, exp_s_cnt[i]);
         check("small_ready", {31'b0, s_rdy}, {31'b0, exp_s_cnt[i] < 2});
         check("small_valid", {31'b0, s_vld}, {31'b0, exp_s_vld[i]});
      end
      #1 s_rd_vld = 1'b0;
`else
      // Throttled stream: ready/LFSR agreement and exact-once delivery are checked by the monitor.
      for (int i = 0; i < 64; i++) wr(32'h100 + i, 32'hC000_0000 + i);
      j = 0;
      for (int k = 0; k < 1000; k++) begin
         addr = 32'h100 + (j % 64); we = 1'b0; rd_vld = 1'b1;
         @(posedge clk); #1;
         if (acc_flag) j++;
      end
`endif

      idle(1);
      for (int t = 0; t < 50 && sb.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      check("scoreboard_drained", sb.size(), 32'd0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Behavioural and synthesizable main-memory slave for the memory side of the cache controller. It is the responder end of the word-addressed memory read/write interface.
- Accepts single-word writes and pipelined single-word read requests. Returns read data in order, with fixed latency and a bounded number of outstanding reads.
- Used as the backing store in cache-subsystem benches. Also used as the FPGA memory model behind the compressed cache.

Parameters:
- ADDR_WIDTH, 32, width of memory_addr (word address).
- WORD_WIDTH, 32, data word width.
- MEM_DEPTH_LOG2, 14, log2 of array depth in words. Index = memory_addr[MEM_DEPTH_LOG2-1:0]; upper bits ignored.
- READ_LATENCY, 4, clock edges from read acceptance to data valid. Legal range 1..16.
- MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads. Legal range 1..16.
- LFSR_SEED, 16'hACE1, seed for the optional throttle LFSR (must be nonzero).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- memory_addr  in  ADDR_WIDTH  word address, shared by read and write.
- memory_write_en  in  1  write strobe; one word is written per cycle when high.
- memory_write_data  in  WORD_WIDTH  write data.
- memory_read_addr_valid  in  1  read request valid.
- memory_read_ready  out  1  responder can accept a read this cycle.
- memory_read_valid  out  1  read data valid; one-cycle pulse per response.
- memory_read_data  out  WORD_WIDTH  read data.
- outstanding_count  out  5  current number of in-flight reads (debug/verification).

Behaviour:
- Reset (rst low, async) drives:
  - memory_read_valid=0, memory_read_data=0, outstanding_count=0.
  - All delay-line valid bits cleared, LFSR=LFSR_SEED.
  - The array is not reset; its contents persist across reset. In simulation, contents are X until written.
- memory_read_ready is combinational: 1 when outstanding_count < MAX_OUTSTANDING (and not throttled, see Optional Feature). Otherwise 0.
- Write:
  - On a posedge with memory_write_en=1, mem[index] <= memory_write_data.
  - No response is generated for a write.
- Read acceptance: occurs on a posedge where memory_read_addr_valid=1, memory_read_ready=1 and memory_write_en=0.
  - Write has priority: when write_en=1 the read is not accepted that cycle, and the requester must hold or retry.
- Read data is sampled from the array at the acceptance edge, so writes completed on earlier edges are visible.
  - A write on a later edge does not alter an in-flight read.
  - The array is read-before-write; the acceptance edge and a write edge never coincide, by the priority rule.
- Pipeline: accepted {valid, data} enters a READ_LATENCY-stage delay line.
  - Accept at edge N gives memory_read_valid=1 with the data during the cycle after edge N+READ_LATENCY-1.
  - READ_LATENCY=1 means valid the cycle right after acceptance.
  - Responses are strictly in order, at most one per cycle. Back-to-back accepts give back-to-back valid pulses.
- memory_read_data holds its last value when memory_read_valid=0. It is not zeroed.
- There is no response back-pressure: the requester must always take memory_read_valid.
- outstanding_count update each edge:
  - Accept only: +1.
  - Response only: -1.
  - Both on the same edge: unchanged.
  - The count never exceeds MAX_OUTSTANDING and never underflows.
- Full case: when MAX_OUTSTANDING < READ_LATENCY, ready drops at full and reasserts in the cycle after the first response retires.
- Address wrap: addresses ≥ 2^MEM_DEPTH_LOG2 alias onto the low index bits.
- Reset mid-operation: all in-flight reads are dropped, no late valid pulses are produced, and ready reasserts once rst is released.

Optional Feature:
- Macro: MEM_RANDOM_STALL_EN.
- With the macro defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances on every edge out of reset.
  - memory_read_ready is additionally forced to 0 when lfsr[1:0]==2'b00, giving about 25% pseudo-random throttling that is deterministic per LFSR_SEED.
  - Writes are never throttled.
- Without the macro: no LFSR is built, and ready depends only on outstanding_count.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10. Read 0x10 with READ_LATENCY=4 → valid pulse exactly 4 edges after acceptance, data=0xDEADBEEF, count returns to 0.
- Write words 0..15 with value 0x1000+i. Assert read_addr_valid continuously for 16 consecutive addresses → 16 consecutive valid pulses, in order, data 0x1000..0x100F.
- MAX_OUTSTANDING=2, READ_LATENCY=4, continuous requests → ready low after 2 accepts, count peaks at 2, no third accept until the first valid.
- Assert memory_write_en and read_addr_valid together at addr 0x20 (new data 0x55) → no read accepted that cycle. A read next cycle returns 0x55.
- Issue 3 reads, then pull rst low before any response → memory_read_valid stays 0, count=0. The array keeps its earlier written values, which a read after reset confirms.
- With MEM_RANDOM_STALL_EN and LFSR_SEED=16'hACE1, 1000 cycles of requests → ready is never high when lfsr[1:0]==0, and every accepted read returns correct data exactly once.
